// File: rtl/ans_table_sequencer_pkg.sv
// Shared sizing, state encoding and count-slice helper for the ANS table sequencer.
package ans_table_sequencer_pkg;

  localparam int unsigned SYM_WIDTH  = 4;
  localparam int unsigned CNT_WIDTH  = 8;
  localparam int unsigned PREC_WIDTH = 8;
  localparam int unsigned NSYM       = 1 << SYM_WIDTH;
  localparam int unsigned SUM_W      = CNT_WIDTH + SYM_WIDTH;

  // A table is valid only when its counts sum to exactly 2**PREC_WIDTH.
  localparam logic [SUM_W-1:0] TOTAL = SUM_W'(1) << PREC_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StBuild,
    StCheck,
    StReady,
    StError
  } state_e;

  function automatic logic [CNT_WIDTH-1:0] count_at(input logic [NSYM*CNT_WIDTH-1:0] flat,
                                                    input logic [SYM_WIDTH-1:0]      i);
    return flat[i*CNT_WIDTH +: CNT_WIDTH];
  endfunction

endpackage

// File: rtl/ans_table_sequencer_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module ans_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset to 1 so requester 0 wins the first contested cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/ans_table_sequencer.sv
// ANS frequency-table sequencer: load, CDF build, total check, shared lookups.
// Optional ANS_ZERO_CHECK_EN also rejects tables containing a zero count.
module ans_table_sequencer
  import ans_table_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      ld_fire,
  input  logic [NSYM*CNT_WIDTH-1:0] counts_flat,
  output logic                      ld_en,
  output logic                      busy,
  output logic                      tbl_ready,
  output logic                      tbl_err,
  input  logic [1:0]                req,
  input  logic [2*SYM_WIDTH-1:0]    req_sym,
  output logic [1:0]                gnt,
  output logic                      rsp_vld,
  output logic                      rsp_id,
  output logic [CNT_WIDTH-1:0]      rsp_cnt,
  output logic [PREC_WIDTH-1:0]     rsp_cum
);

  state_e                state_q, state_d;
  logic [SYM_WIDTH:0]    ld_cnt_q, ld_cnt_d;
  logic [SYM_WIDTH-1:0]  idx_q, idx_d;
  logic [SUM_W-1:0]      acc_q, acc_d;
  logic [PREC_WIDTH-1:0] cum_q [NSYM];
  logic [CNT_WIDTH-1:0]  build_cnt;
  logic                  table_ok;
  logic                  arb_en;
  logic [SYM_WIDTH-1:0]  gnt_sym;

  assign build_cnt = count_at(counts_flat, idx_q);

`ifdef ANS_ZERO_CHECK_EN
  logic zero_q, zero_d;
  assign table_ok = (acc_q == TOTAL) && !zero_q;
`else
  assign table_ok = (acc_q == TOTAL);
`endif

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
`ifdef ANS_ZERO_CHECK_EN
    zero_d   = zero_q;
`endif
    if (start) begin
      // Start from any state restarts a clean load.
      state_d  = StLoad;
      ld_cnt_d = '0;
      idx_d    = '0;
      acc_d    = '0;
`ifdef ANS_ZERO_CHECK_EN
      zero_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StLoad: begin
          if (ld_fire) begin
            ld_cnt_d = ld_cnt_q + 1'b1;
            if (ld_cnt_q == (SYM_WIDTH+1)'(NSYM - 1)) begin
              state_d = StBuild;
            end
          end
        end
        StBuild: begin
          acc_d = acc_q + SUM_W'(build_cnt);
          idx_d = idx_q + 1'b1;
`ifdef ANS_ZERO_CHECK_EN
          if (build_cnt == '0) begin
            zero_d = 1'b1;
          end
`endif
          if (idx_q == SYM_WIDTH'(NSYM - 1)) begin
            state_d = StCheck;
          end
        end
        StCheck: state_d = table_ok ? StReady : StError;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ld_cnt_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
`ifdef ANS_ZERO_CHECK_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
`ifdef ANS_ZERO_CHECK_EN
      zero_q   <= zero_d;
`endif
    end
  end

  // Exclusive prefix sum: entry i holds the total of counts 0..i-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYM; i++) begin
        cum_q[i] <= '0;
      end
    end else if (state_q == StBuild && !start) begin
      cum_q[idx_q] <= acc_q[PREC_WIDTH-1:0];
    end
  end

  assign ld_en     = (state_q == StLoad);
  assign busy      = (state_q == StLoad) || (state_q == StBuild) || (state_q == StCheck);
  assign tbl_ready = (state_q == StReady);
  assign tbl_err   = (state_q == StError);

  assign arb_en = (state_q == StReady) && !start;

  ans_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign gnt_sym = gnt[1] ? req_sym[SYM_WIDTH +: SYM_WIDTH] : req_sym[0 +: SYM_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld <= 1'b0;
      rsp_id  <= 1'b0;
      rsp_cnt <= '0;
      rsp_cum <= '0;
    end else begin
      rsp_vld <= |gnt;
      if (|gnt) begin
        rsp_id  <= gnt[1];
        rsp_cnt <= count_at(counts_flat, gnt_sym);
        rsp_cum <= cum_q[gnt_sym];
      end
    end
  end

endmodule

// File: tb/tb_ans_table_sequencer.sv
// Randomized bench for ans_table_sequencer against a prefix-sum / round-robin reference model.
module tb_ans_table_sequencer;
  import ans_table_sequencer_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic                      ld_fire = 1'b0;
  logic [NSYM*CNT_WIDTH-1:0] counts_flat = '0;
  logic                      ld_en, busy, tbl_ready, tbl_err;
  logic [1:0]                req = 2'b00;
  logic [2*SYM_WIDTH-1:0]    req_sym = '0;
  logic [1:0]                gnt;
  logic                      rsp_vld, rsp_id;
  logic [CNT_WIDTH-1:0]      rsp_cnt;
  logic [PREC_WIDTH-1:0]     rsp_cum;

  int unsigned n_total = 0;
  int unsigned n_bad = 0;
  int unsigned cnts[NSYM];
  bit          exp_ready = 1'b0;
  bit          last_gnt = 1'b1;

  ans_table_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ld_fire     (ld_fire),
    .counts_flat (counts_flat),
    .ld_en       (ld_en),
    .busy        (busy),
    .tbl_ready   (tbl_ready),
    .tbl_err     (tbl_err),
    .req         (req),
    .req_sym     (req_sym),
    .gnt         (gnt),
    .rsp_vld     (rsp_vld),
    .rsp_id      (rsp_id),
    .rsp_cnt     (rsp_cnt),
    .rsp_cum     (rsp_cum)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_counts();
    for (int i = 0; i < NSYM; i++) counts_flat[i*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(cnts[i]);
  endtask

  function automatic bit exp_ok();
    int unsigned s = 0;
    foreach (cnts[i]) s += cnts[i];
`ifdef ANS_ZERO_CHECK_EN
    foreach (cnts[i]) if (cnts[i] == 0) return 1'b0;
`endif
    return s == (1 << PREC_WIDTH);
  endfunction

  function automatic int unsigned exp_cum(input int unsigned sym);
    int unsigned s = 0;
    for (int i = 0; i < int'(sym); i++) s += cnts[i];
    return s % (1 << PREC_WIDTH);
  endfunction

  task automatic gen_valid();
    foreach (cnts[i]) cnts[i] = 1;
    for (int k = 0; k < (1 << PREC_WIDTH) - NSYM; k++) cnts[$urandom_range(0, NSYM-1)]++;
  endtask

  task automatic fire_n(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) step();
      ld_fire = 1'b1;
      step();
      ld_fire = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_ready = 1'b0;
  endtask

  // Caller has just seen the final load fire; walks BUILD and CHECK.
  task automatic build_and_check();
    check_eq("ld_en_after_load", ld_en, 0);
    check_eq("busy_in_build", busy, 1);
    repeat (NSYM) begin
      ld_fire = 1'($urandom_range(0, 1));
      step();
    end
    ld_fire = 1'b0;
    check_eq("ready_before_check", tbl_ready, 0);
    check_eq("busy_in_check", busy, 1);
    step();
    exp_ready = exp_ok();
    check_eq("tbl_ready", tbl_ready, exp_ready);
    check_eq("tbl_err", tbl_err, !exp_ready);
    check_eq("busy_done", busy, 0);
  endtask

  task automatic load_table();
    drive_counts();
    pulse_start();
    check_eq("ld_en_at_start", ld_en, 1);
    check_eq("err_cleared_at_start", tbl_err, 0);
    check_eq("ready_cleared_at_start", tbl_ready, 0);
    fire_n(NSYM - 1);
    check_eq("ld_en_before_last", ld_en, 1);
    fire_n(1);
    build_and_check();
  endtask

  task automatic do_lookup(input logic [1:0] r, input int unsigned s0, input int unsigned s1);
    logic [1:0] eg;
    int unsigned es;
    req = r;
    req_sym = {SYM_WIDTH'(s1), SYM_WIDTH'(s0)};
    #1;
    eg = 2'b00;
    if (exp_ready) begin
      if (r == 2'b11) eg = last_gnt ? 2'b01 : 2'b10;
      else eg = r;
    end
    check_eq("gnt", gnt, eg);
    step();
    check_eq("rsp_vld", rsp_vld, |eg);
    if (|eg) begin
      es = eg[1] ? s1 : s0;
      last_gnt = eg[1];
      check_eq("rsp_id", rsp_id, eg[1]);
      check_eq("rsp_cnt", rsp_cnt, cnts[es]);
      check_eq("rsp_cum", rsp_cum, exp_cum(es));
    end
    req = 2'b00;
  endtask

  task automatic rand_lookups(input int n);
    for (int k = 0; k < n; k++)
      do_lookup(2'($urandom_range(0, 3)), $urandom_range(0, NSYM-1), $urandom_range(0, NSYM-1));
  endtask

  initial begin
    req = 2'b11;
    #2;
    check_eq("rst_ld_en", ld_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", tbl_ready, 0);
    check_eq("rst_err", tbl_err, 0);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_rsp_vld", rsp_vld, 0);
    check_eq("rst_rsp_cnt", rsp_cnt, 0);
    check_eq("rst_rsp_cum", rsp_cum, 0);
    #10;
    rst_n = 1'b1;
    req = 2'b00;
    step();

    // Uniform table: symbol s has count 16 and cum 16*s.
    foreach (cnts[i]) cnts[i] = 16;
    load_table();
    do_lookup(2'b01, 5, 0);
    check_eq("sym5_cum_const", rsp_cum, 80);
    do_lookup(2'b10, 0, 15);
    check_eq("sym15_cum_const", rsp_cum, 240);

    // Total 255 must be rejected, then a valid reload recovers.
    cnts[0] = 15;
    load_table();
    do_lookup(2'b11, 1, 2);
    gen_valid();
    load_table();

    repeat (4) do_lookup(2'b11, $urandom_range(0, NSYM-1), $urandom_range(0, NSYM-1));
    repeat (3) do_lookup(2'b10, $urandom_range(0, NSYM-1), $urandom_range(0, NSYM-1));
    rand_lookups(40);

    // Start in READY blocks grants in that same cycle.
    req = 2'b11;
    start = 1'b1;
    #1;
    check_eq("gnt_forced_off", gnt, 0);
    step();
    start = 1'b0;
    req = 2'b00;
    exp_ready = 1'b0;
    check_eq("ready_drop_on_start", tbl_ready, 0);
    fire_n(NSYM);
    repeat (7) step();
    gen_valid();
    drive_counts();
    pulse_start();
    check_eq("restart_ld_en", ld_en, 1);
    check_eq("restart_busy", busy, 1);
    fire_n(NSYM - 1);
    check_eq("restart_needs_full", ld_en, 1);
    fire_n(1);
    build_and_check();
    rand_lookups(20);

    for (int t = 0; t < 4; t++) begin
      gen_valid();
      if ($urandom_range(0, 1) == 1) begin
        int unsigned j = $urandom_range(0, NSYM-1);
        cnts[j] = cnts[j] + 1;
      end
      load_table();
      rand_lookups(20);
    end

    // Zero count with a correct total.
    foreach (cnts[i]) cnts[i] = 17;
    cnts[0] = 18;
    cnts[3] = 0;
    load_table();
    rand_lookups(10);

    // Asynchronous reset in the middle of a load.
    gen_valid();
    drive_counts();
    pulse_start();
    fire_n(5);
    req = 2'b11;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ld_en", ld_en, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_gnt", gnt, 0);
    check_eq("arst_rsp_vld", rsp_vld, 0);
    check_eq("arst_rsp_cum", rsp_cum, 0);
    rst_n = 1'b1;
    req = 2'b00;
    last_gnt = 1'b1;
    exp_ready = 1'b0;
    step();
    check_eq("idle_after_arst", ld_en, 0);
    load_table();
    rand_lookups(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
